// File: rtl/seg7_scan_decoder_pkg.sv
// Shared constants for the multiplexed 7-segment bus decoder.
// Segment patterns are active-low and ordered a..g, with a in bit 0 of a [0:6] vector.
package seg7_scan_decoder_pkg;

  localparam int unsigned DIGITS_N          = 4;
  localparam int unsigned STABLE_CYCLES_DEF = 4;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0001100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HELD   = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational decode of one active-low segment pattern to a BCD digit.
// An unrecognised pattern, blank included, gives digit 0 with invalid set.
module seg7_to_bcd
  import seg7_scan_decoder_pkg::*;
(
  input  logic [0:6] seg_i,
  output logic [3:0] digit_o,
  output logic       invalid_o
);

  always_comb begin
    digit_o   = 4'd0;
    invalid_o = 1'b0;
    case (seg_i)
      SEG_0:   digit_o = 4'd0;
      SEG_1:   digit_o = 4'd1;
      SEG_2:   digit_o = 4'd2;
      SEG_3:   digit_o = 4'd3;
      SEG_4:   digit_o = 4'd4;
      SEG_5:   digit_o = 4'd5;
      SEG_6:   digit_o = 4'd6;
      SEG_7:   digit_o = 4'd7;
      SEG_8:   digit_o = 4'd8;
      SEG_9:   digit_o = 4'd9;
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Samples a scanned 4-digit 7-segment bus and publishes a BCD frame once
// every digit has been captured after holding stable for STABLE_CYCLES samples.
module seg7_scan_decoder
  import seg7_scan_decoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [3:0]  DIG,
  input  logic [0:6]  SEG,
  output logic [15:0] Value,
  output logic [3:0]  Err,
  output logic        Valid
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);

  state_e            state_q;
  logic [3:0]        dig_q, dig_p_q, mask_q;
  logic [0:6]        seg_q, seg_p_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [15:0]       shadow_val_q, value_q;
  logic [3:0]        shadow_err_q, err_q;
  logic              valid_q;

  logic [3:0]        digit;
  logic              invalid;
  logic              one_hot, stable;
  logic [15:0]       cap_val;
  logic [3:0]        cap_err, mask_nxt;

  seg7_to_bcd u_dec (
    .seg_i     (seg_q),
    .digit_o   (digit),
    .invalid_o (invalid)
  );

  // Shadow contents as they will look once the current slot is written.
  always_comb begin
    one_hot  = $onehot(dig_q);
    stable   = (dig_q == dig_p_q) && (seg_q == seg_p_q);
    cap_val  = shadow_val_q;
    cap_err  = shadow_err_q;
    mask_nxt = mask_q | dig_q;
    for (int i = 0; i < DIGITS_N; i++) begin
      if (dig_q[i]) begin
        cap_val[4*i +: 4] = digit;
        cap_err[i]        = invalid;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q      <= ST_IDLE;
      dig_q        <= 4'b0000;
      dig_p_q      <= 4'b0000;
      seg_q        <= SEG_BLANK;
      seg_p_q      <= SEG_BLANK;
      cnt_q        <= '0;
      mask_q       <= 4'b0000;
      shadow_val_q <= 16'h0000;
      shadow_err_q <= 4'b0000;
      value_q      <= 16'h0000;
      err_q        <= 4'b0000;
      valid_q      <= 1'b0;
    end else begin
      dig_q   <= DIG;
      seg_q   <= SEG;
      dig_p_q <= dig_q;
      seg_p_q <= seg_q;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (one_hot) begin
            state_q <= ST_SETTLE;
            cnt_q   <= '0;
          end
        end
        ST_SETTLE: begin
          if (!stable) begin
            cnt_q   <= '0;
            state_q <= one_hot ? ST_SETTLE : ST_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            // Counter reaches STABLE_CYCLES-1 on this edge: capture the digit.
            cnt_q        <= cnt_q + CNT_W'(1);
            shadow_val_q <= cap_val;
            shadow_err_q <= cap_err;
            state_q      <= ST_HELD;
            if (mask_nxt == 4'hF) begin
              value_q <= cap_val;
              err_q   <= cap_err;
              valid_q <= 1'b1;
              mask_q  <= 4'b0000;
            end else begin
              mask_q  <= mask_nxt;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!stable) begin
            cnt_q   <= '0;
            state_q <= one_hot ? ST_SETTLE : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Value = value_q;
  assign Err   = err_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: hand-computed frames, stability
// boundary, invalid patterns, multi-hot strobes, reset and recapture.
module tb_seg7_scan_decoder;

  localparam int unsigned STABLE = 4;
  localparam logic [0:6]  BLANK  = 7'b1111111;

  logic        Clock;
  logic        Resetn;
  logic [3:0]  DIG;
  logic [0:6]  SEG;
  logic [15:0] Value;
  logic [3:0]  Err;
  logic        Valid;

  int n_cmp  = 0;
  int n_fail = 0;
  int vcount = 0;
  int vbase  = 0;

  seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .DIG    (DIG),
    .SEG    (SEG),
    .Value  (Value),
    .Err    (Err),
    .Valid  (Valid)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Every cycle with Valid high counts, so a stretched pulse shows up as extra.
  always @(negedge Clock) if (Valid === 1'b1) vcount++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [0:6] pat(input int d);
    logic [0:6] p;
    case (d)
      0: p = 7'b0000001;
      1: p = 7'b1001111;
      2: p = 7'b0010010;
      3: p = 7'b0000110;
      4: p = 7'b1001100;
      5: p = 7'b0100100;
      6: p = 7'b0100000;
      7: p = 7'b0001111;
      8: p = 7'b0000000;
      9: p = 7'b0001100;
      default: p = BLANK;
    endcase
    return p;
  endfunction

  // Inputs are applied at a falling edge and held across n rising edges.
  task automatic hold(input logic [3:0] d, input logic [0:6] s, input int n);
    DIG = d;
    SEG = s;
    repeat (n) @(negedge Clock);
  endtask

  task automatic cap(input int slot, input logic [0:6] s);
    logic [3:0] oh;
    oh = 4'(1 << slot);
    hold(oh, s, 6);
  endtask

  task automatic frame(input logic [0:6] s0, input logic [0:6] s1,
                       input logic [0:6] s2, input logic [0:6] s3);
    cap(0, s0);
    cap(1, s1);
    cap(2, s2);
    cap(3, s3);
    hold(4'b0000, BLANK, 3);
  endtask

  function automatic int vdelta();
    return vcount - vbase;
  endfunction

  initial begin
    Resetn = 1'b0;
    DIG    = 4'b0000;
    SEG    = BLANK;
    repeat (3) @(negedge Clock);
    chk("reset_value", 32'(Value), 32'h0000);
    chk("reset_err",   32'(Err),   32'h0);
    chk("reset_valid", 32'(Valid), 32'h0);
    Resetn = 1'b1;
    hold(4'b0000, BLANK, 2);

    // Basic frame 4,3,2,1 on digits 0..3
    vbase = vcount;
    frame(pat(4), pat(3), pat(2), pat(1));
    chk("basic_valid_cnt", 32'(vdelta()), 32'd1);
    chk("basic_value",     32'(Value),    32'h1234);
    chk("basic_err",       32'(Err),      32'h0);

    // Held one sample short of STABLE_CYCLES: no capture for digit 0
    vbase = vcount;
    hold(4'b0001, pat(0), STABLE - 1);
    hold(4'b0000, BLANK, 3);
    cap(1, pat(0));
    cap(2, pat(0));
    cap(3, pat(0));
    hold(4'b0000, BLANK, 3);
    chk("short_no_valid",  32'(vdelta()), 32'd0);
    chk("short_value_held", 32'(Value),   32'h1234);
    cap(0, pat(5));
    hold(4'b0000, BLANK, 3);
    chk("short_valid_cnt", 32'(vdelta()), 32'd1);
    chk("short_value",     32'(Value),    32'h0005);
    chk("short_err",       32'(Err),      32'h0);

    // Blank on digit 2 decodes as invalid 0
    vbase = vcount;
    frame(pat(8), pat(8), BLANK, pat(8));
    chk("blank_valid_cnt", 32'(vdelta()), 32'd1);
    chk("blank_value",     32'(Value),    32'h8088);
    chk("blank_err",       32'(Err),      32'h4);

    // Multi-hot strobe never captures
    vbase = vcount;
    hold(4'b0011, pat(6), 20);
    hold(4'b0000, BLANK, 5);
    chk("multihot_no_valid", 32'(vdelta()), 32'd0);
    chk("multihot_value",    32'(Value),    32'h8088);
    chk("multihot_err",      32'(Err),      32'h4);

    // Reset discards a partial frame
    cap(0, pat(5));
    cap(1, pat(5));
    DIG    = 4'b0000;
    SEG    = BLANK;
    Resetn = 1'b0;
    @(negedge Clock);
    Resetn = 1'b1;
    hold(4'b0000, BLANK, 2);
    chk("rst_mid_value", 32'(Value), 32'h0000);
    vbase = vcount;
    cap(2, pat(9));
    cap(3, pat(9));
    hold(4'b0000, BLANK, 3);
    chk("rst_mid_partial", 32'(vdelta()), 32'd0);
    cap(0, pat(9));
    cap(1, pat(9));
    hold(4'b0000, BLANK, 3);
    chk("rst_mid_valid_cnt", 32'(vdelta()), 32'd1);
    chk("rst_mid_value9",    32'(Value),    32'h9999);
    chk("rst_mid_err",       32'(Err),      32'h0);

    // Recapture of digit 0 overwrites its slot
    vbase = vcount;
    cap(0, pat(7));
    cap(0, pat(2));
    cap(1, pat(0));
    cap(2, pat(0));
    cap(3, pat(0));
    hold(4'b0000, BLANK, 3);
    chk("recap_valid_cnt", 32'(vdelta()), 32'd1);
    chk("recap_value",     32'(Value),    32'h0002);
    chk("recap_err",       32'(Err),      32'h0);

    // Non-blank unknown pattern on digit 3
    vbase = vcount;
    frame(pat(1), pat(1), pat(1), 7'b1111110);
    chk("bad_valid_cnt", 32'(vdelta()), 32'd1);
    chk("bad_value",     32'(Value),    32'h0111);
    chk("bad_err",       32'(Err),      32'h8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, meaning the consecutive unchanged sampled cycles required before a digit is captured (legal range 2..255).
REQ-002 SHALL have port Clock  in  1  the single system clock; all logic rising-edge.
REQ-003 SHALL have port Resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port DIG  in  4  one-hot digit strobe of a multiplexed display bus; DIG[i] selects digit i (0 = least significant).
REQ-005 SHALL have port SEG  in  [0:6]  active-low segment lines a..g (SEG[0]=a, SEG[6]=g).
REQ-006 SHALL have port Value  out  16  captured frame, BCD, digit i in Value[4i+3:4i].
REQ-007 SHALL have port Err  out  4  per-digit invalid-pattern flag of the published frame.
REQ-008 SHALL have port Valid  out  1  one-cycle pulse marking publication of a new Value/Err.

Function
REQ-009 SHALL register DIG and SEG once (dig_q, seg_q) before any decision; the design acts only on the registered copies.
REQ-010 SHALL decode seg_q with the active-low table 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100 (bits a..g); any other pattern, blank 1111111 included, SHALL decode to digit 0 with invalid=1.
REQ-011 SHALL run FSM states IDLE, SETTLE, HELD.
REQ-012 IDLE: SHALL move to SETTLE with stability counter cleared when dig_q is exactly one-hot.
REQ-013 SETTLE: SHALL increment the counter on each edge where dig_q and seg_q equal their values on the previous edge; any change SHALL clear the counter and stay in SETTLE (or go to IDLE if dig_q is not one-hot).
REQ-014 SETTLE: on the edge the counter reaches STABLE_CYCLES-1, SHALL write the decoded digit and invalid flag into shadow slot i, set capture-mask bit i, and go to HELD.
REQ-015 HELD: SHALL perform no further capture until dig_q or seg_q changes, then go to SETTLE (one-hot) or IDLE (otherwise).
REQ-016 Timing: with DIG/SEG constant and sampled first at edge E0, capture SHALL occur at edge E0+STABLE_CYCLES.
REQ-017 DIG zero or multi-hot SHALL never capture and SHALL not alter the mask.
REQ-018 Recapture of a digit whose mask bit is already set SHALL overwrite that shadow slot; the mask is unchanged.
REQ-019 When a capture makes the mask 1111, on that same edge Value and Err SHALL load from the shadow (including the just-captured slot), Valid SHALL be 1 for the following cycle only, and the mask SHALL clear.
REQ-020 Value and Err SHALL hold between publications; Valid SHALL be 0 in all other cycles.
REQ-021 Counter SHALL be wide enough for STABLE_CYCLES-1 and SHALL never wrap.

Reset
REQ-022 While Resetn=0 at an edge: state=IDLE, counter=0, mask=0000, shadow=0, dig_q=0000, seg_q=1111111, Value=0x0000, Err=0000, Valid=0.
REQ-023 Reset mid-SETTLE or with a partial frame SHALL discard all partial captures; no Valid follows reset until four fresh captures complete.

Structure
REQ-024 A shared package SHALL hold the ten segment-pattern constants, the blank constant, the STABLE_CYCLES default, and the FSM state encoding.
REQ-025 One sub-module, seg7_to_bcd (combinational: 7-bit pattern -> 4-bit digit + invalid), SHALL be instantiated once on seg_q.

Verification
REQ-026 Reset, then drive digits 0..3 with patterns for 4,3,2,1, each held 6 cycles -> one Valid pulse, Value=0x1234, Err=0000.
REQ-027 Hold DIG=0001, SEG=0000001 for exactly STABLE_CYCLES-1 cycles, then change -> no capture, mask unchanged.
REQ-028 Frame with digit 2 = 1111111 and others 0000000 -> Value=0x8088, Err=0100.
REQ-029 DIG=0011 held 20 cycles, then DIG=0000 -> no capture, no Valid.
REQ-030 Capture digits 0,1 with 5,5, assert Resetn=0 one cycle, then capture all four as 9 -> exactly one Valid, Value=0x9999.
REQ-031 Capture digit 0 as 7, recapture as 2, complete frame with 0s -> Value=0x0002, one Valid.
